// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit.
// Holds the state encoding and the default operand width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DBZ  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration, purely combinational.
// The subtract is one bit wider so its MSB is the borrow.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit and restore on borrow
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU beside the EX stage.
// Returns {remainder, quotient}; busy stalls the pipe while iterating.
import div_unit_pkg::*;

module div_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    div_state_e       nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             sdiv;
    logic             qsign;
    logic             rsign;

    logic [WIDTH-1:0] xabs;
    logic [WIDTH-1:0] yabs;
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             last;
    logic             launch;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem),
        .dividend_bit (dq[WIDTH-1]),
        .divisor      (dvs),
        .rem_out      (rem_nx),
        .q_bit        (qbit)
    );

    // Operand magnitudes, final quotient and sign fix-up
    always_comb begin
        xabs   = (signed_div && x[WIDTH-1]) ? -x : x;
        yabs   = (signed_div && y[WIDTH-1]) ? -y : y;
        q_fin  = {dq[WIDTH-2:0], qbit};
        q_out  = (sdiv && qsign) ? -q_fin : q_fin;
        r_out  = (sdiv && rsign) ? -rem_nx : rem_nx;
        last   = (cnt == CW'(WIDTH - 1));
        launch = start && !annul;
    end

    // Next state and handshake outputs
    always_comb begin
        nxt   = state;
        busy  = 1'b0;
        ready = 1'b0;
        unique case (state)
            DIV_IDLE: begin
                if (launch)
                    nxt = (y == '0) ? DIV_DBZ : DIV_RUN;
            end
            DIV_RUN: begin
                busy = 1'b1;
                if (annul)
                    nxt = DIV_IDLE;
                else if (last)
                    nxt = DIV_DONE;
            end
            DIV_DBZ: begin
                busy = 1'b1;
                nxt  = annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_DONE: begin
                ready = 1'b1;
                nxt   = DIV_IDLE;
            end
        endcase
    end

    // State register, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            dq     <= '0;
            dvs    <= '0;
            rem    <= '0;
            sdiv   <= 1'b0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            result <= '0;
        end else begin
            state <= nxt;
            if (state == DIV_IDLE && launch) begin
                dq    <= xabs;
                dvs   <= yabs;
                rem   <= '0;
                cnt   <= '0;
                sdiv  <= signed_div;
                qsign <= x[WIDTH-1] ^ y[WIDTH-1];
                rsign <= x[WIDTH-1];
            end
            if (state == DIV_RUN && !annul) begin
                dq  <= q_fin;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (last)
                    result <= {r_out, q_out};
            end
            if (state == DIV_DBZ && !annul)
                result <= '0;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Expected results are queued at launch and checked on ready.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_div;
    logic          annul;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          busy;
    logic          ready;
    logic [2*W-1:0] result;

    int ntest = 0;
    int nfail = 0;
    int nrdy  = 0;
    logic [2*W-1:0] sb[$];

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ready) nrdy++;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sd;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sd = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sd = longint'({32'd0, b});
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic launch(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input bit push,
                          input bit hold);
        @(negedge clk);
        start = 1'b1;
        signed_div = s;
        x = a;
        y = b;
        if (push) sb.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        x = $urandom;
        y = $urandom;
    endtask

    task automatic wait_done(input string tag, output int edges,
                             output int bcyc, output logic [63:0] res);
        logic [63:0] e;
        edges = 1;
        bcyc  = 0;
        res   = '0;
        if (busy) bcyc++;
        while (!ready && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) bcyc++;
        end
        start = 1'b0;
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        if (ready) begin
            res = result;
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_res"}, result, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_edges, output logic [63:0] res);
        int ed;
        int bc;
        launch(s, a, b, 1'b1, 1'b0);
        wait_done(tag, ed, bc, res);
        chk({tag, "_lat"}, 64'(ed), 64'(exp_edges));
        chk({tag, "_busy"}, 64'(bc), 64'(exp_edges - 1));
    endtask

    logic [63:0] r;
    logic [63:0] prior;
    int n0;
    int ed;
    int bc;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        signed_div = 1'b0;
        annul = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, r);
        chk("divu_100_7_k", r, {32'd2, 32'd14});

        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, r);
        chk("div_m7_2_k", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, r);
        chk("div_ovf_k", r, {32'd0, 32'h8000_0000});
        do_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, r);
        chk("divu_ovf_k", r, {32'h8000_0000, 32'd0});

        do_op("dbz_s", 1'b1, 32'd1234, 32'd0, 2, r);
        chk("dbz_s_k", r, 64'd0);
        do_op("dbz_u", 1'b0, 32'hFFFF_0000, 32'd0, 2, r);
        chk("dbz_u_k", r, 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i < 4) ? $urandom_range(1, 1000) : $urandom;
            if (b == 32'd0) b = 32'd3;
            do_op("rand", i[0], a, b, 33, r);
        end

        prior = r;
        n0 = nrdy;
        launch(1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_keep", result, prior);
        do_op("after_annul", 1'b0, 32'd9, 32'd4, 33, r);
        chk("after_annul_k", r, {32'd1, 32'd2});
        chk("annul_pulses", 64'(nrdy - n0), 64'd1);

        launch(1'b0, 32'h0000_FFFF, 32'd3, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_ready", 64'(ready), 64'd0);
        chk("mrst_result", result, 64'd0);

        @(negedge clk);
        start = 1'b1;
        annul = 1'b1;
        y = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        chk("start_annul_idle", 64'(busy), 64'd0);

        n0 = nrdy;
        launch(1'b0, 32'd1000, 32'd10, 1'b1, 1'b1);
        wait_done("held", ed, bc, r);
        chk("held_k", r, {32'd0, 32'd100});
        repeat (40) @(posedge clk);
        #1;
        chk("held_pulses", 64'(nrdy - n0), 64'd1);
        chk("held_idle", 64'(busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
